// File: rtl/lfsr_stream_decrypt.sv
// Receive-side LFSR stream decrypter: XORs accepted ciphertext with an 8-bit keystream,
// re-keys every FRAME_LEN bytes and buffers plaintext in a small output FIFO.
module lfsr_stream_decrypt #(
    parameter logic [7:0]  SEED       = 8'h41,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       seed_load,
    input  logic [7:0] seed_value,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_done,
    output logic [7:0] byte_count
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, REKEY} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } entry_t;

    state_t           state_q;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       key_q, key_d;
    logic [7:0]       cnt_q, cnt_d;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q;

    logic full, pop, load, accept, is_last, fb;

    assign full     = (fill_q == CNT_W'(FIFO_DEPTH));
    assign load     = ena & seed_load;
    assign pop      = ena & out_valid_q & out_ready;
    assign in_ready = (state_q == RUN) & ena & ~seed_load & (~full | out_ready);
    assign accept   = in_valid & in_ready;
    assign is_last  = (cnt_q == LAST_IDX);
    assign fb       = lfsr_q[0] ^ lfsr_q[5] ^ lfsr_q[6] ^ lfsr_q[7];

    // Next-state for keystream, frame counter and FIFO; the head register tracks the new FIFO head.
    always_comb begin
        lfsr_d = lfsr_q;
        key_d  = key_q;
        cnt_d  = cnt_q;
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        fill_d = fill_q;
        if (load) begin
            key_d  = seed_value;
            lfsr_d = seed_value;
            cnt_d  = '0;
            rd_d   = '0;
            wr_d   = '0;
            fill_d = '0;
        end else begin
            if (accept) begin
                mem_d[wr_q] = '{data: in_data ^ lfsr_q, last: is_last};
                wr_d        = wr_q + PTR_W'(1);
                lfsr_d      = is_last ? key_q : {lfsr_q[6:0], fb};
                cnt_d       = is_last ? 8'd0 : cnt_q + 8'd1;
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            fill_d = fill_q + CNT_W'(accept) - CNT_W'(pop);
        end
        out_valid_d = (fill_d != '0);
        out_data_d  = out_valid_d ? mem_d[rd_d].data : out_data_q;
        out_last_d  = out_valid_d ? mem_d[rd_d].last : out_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            key_q        <= SEED;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            fill_q       <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (ena) begin
                case (state_q)
                    IDLE:    state_q <= load ? REKEY : RUN;
                    RUN:     state_q <= load ? REKEY : RUN;
                    REKEY:   state_q <= load ? REKEY : RUN;
                    default: state_q <= IDLE;
                endcase
            end
            lfsr_q       <= lfsr_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            fill_q       <= fill_d;
            mem_q        <= mem_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= accept & is_last;
        end
    end

    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Bench for lfsr_stream_decrypt: directed scenarios plus a randomized run against a
// keystream-by-position reference model with a plaintext queue.
module tb_lfsr_stream_decrypt;

    localparam int FL    = 4;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, seed_load, in_valid, out_ready;
    logic [7:0] seed_value, in_data;
    logic       in_ready, out_valid, out_last, frame_done;
    logic [7:0] out_data, byte_count;

    lfsr_stream_decrypt #(.SEED(8'h41), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seed_load(seed_load), .seed_value(seed_value),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    ent_t       mq[$];
    logic [7:0] m_key;
    int         m_pos;
    bit         m_live, m_rekey, m_fd;
    logic [7:0] m_od;
    logic       m_ol;
    logic       exp_ir, got_ir;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        logic b;
        b = q[0] ^ q[5] ^ q[6] ^ q[7];
        return {q[6:0], b};
    endfunction

    // Keystream byte at a given position within a frame keyed by 'key'.
    function automatic logic [7:0] ks(input logic [7:0] key, input int pos);
        logic [7:0] k;
        k = key;
        for (int i = 0; i < pos; i++) k = lfsr_next(k);
        return k;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_key = 8'h41; m_pos = 0; m_live = 0; m_rekey = 0; m_fd = 0; m_od = 8'h00; m_ol = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b0; seed_load = 1'b0; seed_value = 8'h00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs at negedge, capture in_ready, advance the model at posedge.
    task automatic cyc(input logic e, input logic s, input logic [7:0] sv,
                       input logic v, input logic [7:0] d, input logic r);
        bit   acc, pop;
        ent_t en;
        @(negedge clk);
        ena = e; seed_load = s; seed_value = sv; in_valid = v; in_data = d; out_ready = r;
        #1;
        got_ir = in_ready;
        exp_ir = m_live && !m_rekey && e && !s && ((mq.size() < DEPTH) || r);
        @(posedge clk);
        m_fd = 0;
        if (e) begin
            acc = v && exp_ir;
            pop = r && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (s) begin
                mq.delete();
                m_key = sv; m_pos = 0; m_rekey = 1;
            end else begin
                m_rekey = 0;
                if (acc) begin
                    en.d = d ^ ks(m_key, m_pos);
                    en.l = (m_pos == FL - 1);
                    mq.push_back(en);
                    m_fd  = (m_pos == FL - 1);
                    m_pos = (m_pos + 1) % FL;
                end
            end
            m_live = 1;
        end
        if (mq.size() > 0) begin
            m_od = mq[0].d; m_ol = mq[0].l;
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b1; out_ready = 1'b1; seed_load = 1'b0;
        in_data = 8'h55; seed_value = 8'h00;
        model_reset();
        @(posedge clk); #1;
        n_tests++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL reset in_ready got %b exp 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        n_tests++; if (out_data !== 8'h00)  begin n_fail++; $display("FAIL reset out_data got %h exp 00", out_data); end
        n_tests++; if (out_last !== 1'b0)   begin n_fail++; $display("FAIL reset out_last got %b exp 0", out_last); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done got %b exp 0", frame_done); end
        n_tests++; if (byte_count !== 8'd0) begin n_fail++; $display("FAIL reset byte_count got %0d exp 0", byte_count); end
        @(negedge clk);
        ena = 1'b0; rst_n = 1'b1;
        cyc(1, 0, 8'h00, 1, 8'h41, 1);
        n_tests++; if (got_ir !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got %b exp 0", got_ir); end
    endtask

    task automatic test_keystream();
        logic [7:0] ct [4];
        ct[0] = 8'h41; ct[1] = 8'h82; ct[2] = 8'h05; ct[3] = 8'h0B;
        do_reset();
        cyc(1, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 8'h00, 1, ct[i], 1);
            n_tests++; if (got_ir !== 1'b1) begin n_fail++; $display("FAIL keystream[%0d] in_ready got %b exp 1", i, got_ir); end
            n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h00)
                begin n_fail++; $display("FAIL keystream[%0d] out valid/data got %b/%h exp 1/00", i, out_valid, out_data); end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_rdy;
        exp_rdy = 3'b011;
        do_reset();
        cyc(1, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00, 1, 8'h00, 0);
            n_tests++; if (got_ir !== exp_rdy[i]) begin n_fail++; $display("FAIL backpressure in_ready[%0d] got %b exp %b", i, got_ir, exp_rdy[i]); end
        end
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_fail++; $display("FAIL backpressure head got %b/%h exp 1/41", out_valid, out_data); end
        cyc(1, 0, 8'h00, 1, 8'h00, 1);
        n_tests++; if (got_ir !== 1'b1) begin n_fail++; $display("FAIL backpressure full_pop in_ready got %b exp 1", got_ir); end
        n_tests++; if (out_data !== 8'h82) begin n_fail++; $display("FAIL backpressure out1 got %h exp 82", out_data); end
        cyc(1, 0, 8'h00, 0, 8'h00, 1);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h05) begin n_fail++; $display("FAIL backpressure out2 got %b/%h exp 1/05", out_valid, out_data); end
        cyc(1, 0, 8'h00, 0, 8'h00, 1);
        n_tests++; if (out_valid !== 1'b0 || out_data !== 8'h05) begin n_fail++; $display("FAIL backpressure drained got %b/%h exp 0/05", out_valid, out_data); end
    endtask

    task automatic test_stall();
        logic [7:0] ex [3];
        ex[0] = 8'h41; ex[1] = 8'h82; ex[2] = 8'h05;
        do_reset();
        cyc(1, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00, 1, 8'h00, 1);
            n_tests++; if (out_valid !== 1'b1 || out_data !== ex[i]) begin n_fail++; $display("FAIL stall out[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, ex[i]); end
            repeat (5) cyc(1, 0, 8'h00, 0, 8'h00, 1);
            n_tests++; if (out_valid !== 1'b0 || byte_count !== 8'(i + 1))
                begin n_fail++; $display("FAIL stall idle[%0d] valid/count got %b/%0d exp 0/%0d", i, out_valid, byte_count, i + 1); end
        end
    endtask

    task automatic test_frame();
        logic [7:0] ex [5];
        int pulses;
        ex[0] = 8'h41; ex[1] = 8'h82; ex[2] = 8'h05; ex[3] = 8'h0B; ex[4] = 8'h41;
        pulses = 0;
        do_reset();
        cyc(1, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'h00, 1, 8'h00, 1);
            if (frame_done === 1'b1) pulses++;
            n_tests++; if (out_data !== ex[i] || out_last !== (i == 3))
                begin n_fail++; $display("FAIL frame out[%0d] data/last got %h/%b exp %h/%b", i, out_data, out_last, ex[i], (i == 3)); end
            n_tests++; if (frame_done !== (i == 3)) begin n_fail++; $display("FAIL frame frame_done[%0d] got %b exp %b", i, frame_done, (i == 3)); end
        end
        cyc(1, 0, 8'h00, 0, 8'h00, 1);
        if (frame_done === 1'b1) pulses++;
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL frame pulses got %0d exp 1", pulses); end
        n_tests++; if (byte_count !== 8'd1) begin n_fail++; $display("FAIL frame byte_count got %0d exp 1", byte_count); end
    endtask

    task automatic test_seed_load();
        do_reset();
        cyc(1, 0, 8'h00, 0, 8'h00, 0);
        repeat (2) cyc(1, 0, 8'h00, 1, 8'h00, 0);
        cyc(1, 1, 8'h05, 1, 8'h00, 0);
        n_tests++; if (got_ir !== 1'b0) begin n_fail++; $display("FAIL seed_load in_ready got %b exp 0", got_ir); end
        n_tests++; if (out_valid !== 1'b0 || byte_count !== 8'd0) begin n_fail++; $display("FAIL seed_load flush valid/count got %b/%0d exp 0/0", out_valid, byte_count); end
        cyc(1, 0, 8'h00, 1, 8'h00, 1);
        n_tests++; if (got_ir !== 1'b0) begin n_fail++; $display("FAIL rekey in_ready got %b exp 0", got_ir); end
        cyc(1, 0, 8'h00, 1, 8'h00, 1);
        n_tests++; if (got_ir !== 1'b1 || out_data !== 8'h05 || byte_count !== 8'd1)
            begin n_fail++; $display("FAIL seed_load first got rdy %b data %h cnt %0d exp 1/05/1", got_ir, out_data, byte_count); end
        cyc(1, 0, 8'h00, 1, 8'h00, 1);
        n_tests++; if (out_data !== 8'h0B) begin n_fail++; $display("FAIL seed_load second got %h exp 0B", out_data); end
    endtask

    task automatic test_ena_freeze();
        do_reset();
        cyc(1, 0, 8'h00, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 1, 8'h00, 0);
        repeat (3) begin
            cyc(0, 0, 8'h00, 1, 8'h00, 1);
            n_tests++; if (got_ir !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h41 || byte_count !== 8'd1)
                begin n_fail++; $display("FAIL freeze got rdy %b valid %b data %h cnt %0d exp 0/1/41/1", got_ir, out_valid, out_data, byte_count); end
        end
        cyc(1, 0, 8'h00, 1, 8'h00, 1);
        n_tests++; if (out_data !== 8'h82) begin n_fail++; $display("FAIL freeze resume got %h exp 82", out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1, 0, 8'h00, 0, 8'h00, 0);
        repeat (2) cyc(1, 0, 8'h00, 1, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid out_valid got %b exp 0", out_valid); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 8'h00, 0, 8'h00, 1);
        cyc(1, 0, 8'h00, 1, 8'h00, 1);
        n_tests++; if (out_data !== 8'h41) begin n_fail++; $display("FAIL reset_mid first got %h exp 41", out_data); end
    endtask

    task automatic test_random();
        logic e, s, v, r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            cyc(e, s, 8'($urandom), v, 8'($urandom), r);
            n_tests++; if (got_ir !== exp_ir) begin n_fail++; $display("FAIL rand[%0d] in_ready got %b exp %b", i, got_ir, exp_ir); end
            n_tests++; if (out_valid !== (mq.size() > 0) || out_data !== m_od || out_last !== m_ol)
                begin n_fail++; $display("FAIL rand[%0d] out v/d/l got %b/%h/%b exp %b/%h/%b", i, out_valid, out_data, out_last, (mq.size() > 0), m_od, m_ol); end
            n_tests++; if (frame_done !== m_fd || byte_count !== 8'(m_pos))
                begin n_fail++; $display("FAIL rand[%0d] done/count got %b/%0d exp %b/%0d", i, frame_done, byte_count, m_fd, m_pos); end
        end
    endtask

    initial begin
        rst_n = 1'b1; ena = 1'b0; seed_load = 1'b0; seed_value = 8'h00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_keystream();
        test_backpressure();
        test_stall();
        test_frame();
        test_seed_load();
        test_ena_freeze();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_decrypt.md
Name: lfsr_stream_decrypt

Overview:
- Receive-side stage that consumes the ciphertext byte stream produced by the team's LFSR stream encrypter and recovers plaintext.
- XORs each accepted byte with a local 8-bit LFSR keystream. The LFSR uses the same polynomial and seed as the encrypter.
- The keystream advances once per accepted byte, not once per clock, so upstream stalls cannot desynchronise it.
- Adds a valid/ready handshake, a small output FIFO, per-frame re-keying and a seed-load resynchronisation command.

Parameters:
- SEED, 8'h41, LFSR value after reset and at every frame boundary when no seed_load has been issued.
- FRAME_LEN, 16, bytes per frame (legal range 1..255). The LFSR re-keys after this many bytes.
- FIFO_DEPTH, 2, output buffer entries (power of two, ≥2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable. When 0: in_ready=0 and no state advances; outputs hold.
- seed_load  input  1  single-cycle command that loads seed_value as the new key
- seed_value  input  8  new key, sampled when seed_load=1
- in_data  input  8  ciphertext byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a byte this cycle
- out_data  output  8  plaintext byte (FIFO head)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_last  output  1  FIFO head is the last byte of its frame
- frame_done  output  1  one-cycle pulse when a frame's last byte is accepted at the input
- byte_count  output  8  bytes accepted in the current frame, 0..FRAME_LEN-1

Behaviour:
- LFSR next-state rule: next = {q[6:0], q[0]^q[5]^q[6]^q[7]}. The keystream byte equals the current q.
- Reset (async, rst_n=0) puts every register in a defined state:
  - lfsr=SEED, key register=SEED, FIFO empty.
  - out_valid=0, out_data=0, out_last=0, frame_done=0, byte_count=0.
  - in_ready=0 during reset; state=IDLE.
- State machine: IDLE, RUN, REKEY.
  - IDLE → RUN on the first clock with ena=1 after reset release. IDLE drives in_ready=0.
  - RUN: in_ready = ena & !seed_load & (FIFO not full, or FIFO full and out_ready this cycle).
  - Accept occurs when in_valid & in_ready. On accept:
    - push {in_data ^ lfsr, last}, where last = (byte_count == FRAME_LEN-1);
    - advance lfsr;
    - increment byte_count.
  - On accepting the last byte: byte_count←0, lfsr←key register (not advanced), frame_done=1 next cycle, state stays RUN.
  - REKEY: entered on seed_load from RUN or IDLE. Lasts exactly one cycle with in_ready=0, then returns to RUN.
- seed_load:
  - Highest priority. Any byte presented in the same cycle is not accepted (in_ready=0).
  - Key register←seed_value, lfsr←seed_value, byte_count←0, FIFO flushed (out_valid=0 next cycle).
  - A FIFO entry popped in that same cycle counts as delivered.
- Latency: a byte accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 if the FIFO was empty.
- Throughput: one byte per cycle sustained while out_ready=1.
- FIFO rules:
  - Simultaneous push and pop when full is allowed.
  - When empty, a pop is ignored.
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - out_data holds its last value when out_valid=0.
- ena=0 mid-frame freezes lfsr, byte_count, FIFO and state. Resuming continues the keystream exactly.
- rst_n asserted mid-operation discards FIFO contents immediately. No partial outputs.
- byte_count wraps only via the frame-boundary rule; it never reaches FRAME_LEN.

Test Plan:
- Keystream after reset: reset, feed ciphertext 0x41, 0x82, 0x05, 0x0B with out_ready=1 → plaintext 0x00, 0x00, 0x00, 0x00 on consecutive cycles, first at accept+1.
- Backpressure: hold out_ready=0, offer 3 bytes of 0x00 → bytes 0x41 and 0x82 are accepted and in_ready drops to 0 after 2 accepts. Then out_ready=1 → outputs 0x41, 0x82, then 0x05, with no loss or duplication.
- Input stall: insert 5 idle cycles (in_valid=0) between bytes 0x00 → outputs are still 0x41, 0x82, 0x05. Stalls do not advance the LFSR.
- Frame boundary, FRAME_LEN=4: stream 5 bytes of 0x00 →
  - outputs 0x41, 0x82, 0x05, 0x0B, 0x41;
  - out_last=1 on the 4th output only;
  - frame_done pulses once;
  - byte_count reads 1 at the end.
- seed_load: after 2 bytes, pulse seed_load with seed_value=0x05 while in_valid=1 →
  - in_ready=0 that cycle and for the REKEY cycle;
  - any undelivered FIFO entries are flushed;
  - the next 0x00 input yields 0x05, then 0x0B;
  - byte_count restarts at 0.
- Reset mid-frame: assert rst_n=0 while the FIFO holds 2 entries → out_valid=0 immediately (async). After release, the first 0x00 input yields 0x41.
